// File: rtl/vga_sync_gen.sv
// vga_sync_gen: vertical half of the VGA timing chain.
// Consumes the upstream horizontal pixel count and its end-of-line flag and produces
// registered sync, blanking, coordinate and strobe outputs for the pixel renderer.
//
// Ports:
//   Clk           system clock
//   Reset         synchronous, active-high reset
//   cntHorizontal horizontal pixel count 0..799 (advances every second Clk)
//   vflag         one-Clk line-wrap pulse, coincident with cntHorizontal = 0
//   hsync, vsync  registered sync outputs, active level SYNC_POL
//   video_on      high only inside the visible window
//   pixel_x       registered copy of cntHorizontal
//   pixel_y       current line 0..V_TOTAL-1
//   pixel_tick    one-Clk pulse whenever pixel_x changes
//   frame_tick    one-Clk pulse on the first cycle of each frame
//   frame_count   frames since reset, modulo 256
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] cntHorizontal,
  input  logic       vflag,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_tick,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HVisEnd    = 10'(H_VISIBLE);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] VVisEnd    = 10'(V_VISIBLE);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VBackStart = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {StActive, StFront, StSync, StBack} v_state_e;

  v_state_e   state_q, state_d;
  logic [9:0] v_line_q, v_line_d;
  logic [9:0] h_prev_q, h_prev_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       pixel_tick_q, pixel_tick_d;
  logic       frame_tick_q, frame_tick_d;
  logic       h_in_range;

  // Vertical line counter and FSM; only vflag advances the line.
  always_comb begin
    v_line_d      = v_line_q;
    state_d       = state_q;
    frame_count_d = frame_count_q;
    frame_tick_d  = 1'b0;
    if (vflag) begin
      if (v_line_q == VLast) begin
        v_line_d      = '0;
        state_d       = StActive;
        frame_tick_d  = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
      end else begin
        v_line_d = v_line_q + 10'd1;
        if (v_line_d == VVisEnd) begin
          state_d = StFront;
        end else if (v_line_d == VSyncStart) begin
          state_d = StSync;
        end else if (v_line_d == VBackStart) begin
          state_d = StBack;
        end
      end
    end
  end

  // Outputs use the effective line (v_line_d) so pixel_y and pixel_x move together.
  always_comb begin
    h_in_range   = (cntHorizontal <= HLast);
    h_prev_d     = cntHorizontal;
    pixel_x_d    = cntHorizontal;
    pixel_y_d    = v_line_d;
    pixel_tick_d = (cntHorizontal != h_prev_q);
    hsync_d      = ~SYNC_POL;
    if (h_in_range && (cntHorizontal >= HSyncStart) && (cntHorizontal < HSyncEnd)) begin
      hsync_d = SYNC_POL;
    end
    vsync_d    = (state_d == StSync) ? SYNC_POL : ~SYNC_POL;
    video_on_d = h_in_range && (cntHorizontal < HVisEnd) && (v_line_d < VVisEnd);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StActive;
      v_line_q      <= '0;
      h_prev_q      <= '0;
      frame_count_q <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_tick_q  <= 1'b0;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      v_line_q      <= v_line_d;
      h_prev_q      <= h_prev_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pixel_tick_q  <= pixel_tick_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_tick  = pixel_tick_q;
  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed testbench for vga_sync_gen: default instance, an active-high sync instance
// and a short-frame instance used to reach the frame_count wrap quickly.
module tb_vga_sync_gen;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] cnt_h;
  logic       vflag;
  logic       vflag_s;

  logic       hsync, vsync, video_on, pixel_tick, frame_tick;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] frame_count;
  logic       p_hsync, p_vsync, p_video_on, p_pixel_tick, p_frame_tick;
  logic [9:0] p_pixel_x, p_pixel_y;
  logic [7:0] p_frame_count;
  logic       s_hsync, s_vsync, s_video_on, s_pixel_tick, s_frame_tick;
  logic [9:0] s_pixel_x, s_pixel_y;
  logic [7:0] s_frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] last_cnt = '0;
  int hs_low, hs_first, phs_high, vs_low, pvs_high, vo_high, tick_cnt, tick_err, y_err;

  always #10 Clk = ~Clk;

  vga_sync_gen u_dut (
    .Clk(Clk), .Reset(Reset), .cntHorizontal(cnt_h), .vflag(vflag),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pixel_tick(pixel_tick), .frame_tick(frame_tick),
    .frame_count(frame_count)
  );

  vga_sync_gen #(.SYNC_POL(1'b1)) u_pol (
    .Clk(Clk), .Reset(Reset), .cntHorizontal(cnt_h), .vflag(vflag),
    .hsync(p_hsync), .vsync(p_vsync), .video_on(p_video_on), .pixel_x(p_pixel_x),
    .pixel_y(p_pixel_y), .pixel_tick(p_pixel_tick), .frame_tick(p_frame_tick),
    .frame_count(p_frame_count)
  );

  // 7-line frame so 256 frames fit in a short run.
  vga_sync_gen #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_small (
    .Clk(Clk), .Reset(Reset), .cntHorizontal(cnt_h), .vflag(vflag_s),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on), .pixel_x(s_pixel_x),
    .pixel_y(s_pixel_y), .pixel_tick(s_pixel_tick), .frame_tick(s_frame_tick),
    .frame_count(s_frame_count)
  );

  // Drive inputs, clock once, then settle 1 ns past the edge before sampling.
  task automatic step(input int c, input logic vf);
    cnt_h = 10'(c);
    vflag = vf;
    @(posedge Clk);
    #1;
    last_cnt = cnt_h;
  endtask

  task automatic clr_counts();
    hs_low = 0; hs_first = -1; phs_high = 0; vs_low = 0; pvs_high = 0;
    vo_high = 0; tick_cnt = 0; tick_err = 0; y_err = 0;
  endtask

  // One full line of the upstream pattern (each count held 2 Clk), accumulating stats.
  task automatic drive_line(input logic first_vf, input int exp_y);
    logic exp_tick;
    for (int k = 0; k < 1600; k++) begin
      exp_tick = (10'(k / 2) != last_cnt);
      step(k / 2, (k == 0) ? first_vf : 1'b0);
      if (pixel_y !== 10'(exp_y)) y_err++;
      if (hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (p_hsync === 1'b1) phs_high++;
      if (vsync === 1'b0) vs_low++;
      if (p_vsync === 1'b1) pvs_high++;
      if (video_on === 1'b1) vo_high++;
      if (pixel_tick === 1'b1) tick_cnt++;
      if (pixel_tick !== exp_tick) tick_err++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    vflag_s = 1'b0;
    step(0, 1'b0);
    step(0, 1'b0);
    n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL rst_hsync got %b want 1", hsync); end
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL rst_vsync got %b want 1", vsync); end
    n_cmp++; if (video_on !== 1'b0) begin n_bad++; $display("FAIL rst_video_on got %b want 0", video_on); end
    n_cmp++; if (pixel_x !== 10'd0) begin n_bad++; $display("FAIL rst_pixel_x got %0d want 0", pixel_x); end
    n_cmp++; if (pixel_y !== 10'd0) begin n_bad++; $display("FAIL rst_pixel_y got %0d want 0", pixel_y); end
    n_cmp++; if (pixel_tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick got %b want 0", pixel_tick); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL rst_ftick got %b want 0", frame_tick); end
    n_cmp++; if (frame_count !== 8'd0) begin n_bad++; $display("FAIL rst_fcount got %0d want 0", frame_count); end
    n_cmp++; if (p_hsync !== 1'b0) begin n_bad++; $display("FAIL rst_pol_hsync got %b want 0", p_hsync); end
    n_cmp++; if (p_vsync !== 1'b0) begin n_bad++; $display("FAIL rst_pol_vsync got %b want 0", p_vsync); end
    Reset = 1'b0;
  endtask

  task automatic test_line();
    clr_counts();
    drive_line(1'b0, 0);
    n_cmp++; if (hs_low !== 192) begin n_bad++; $display("FAIL line_hsync_len got %0d want 192", hs_low); end
    n_cmp++; if (hs_first !== 1312) begin n_bad++; $display("FAIL line_hsync_start got %0d want 1312", hs_first); end
    n_cmp++; if (phs_high !== 192) begin n_bad++; $display("FAIL line_pol_hsync_len got %0d want 192", phs_high); end
    n_cmp++; if (vo_high !== 1280) begin n_bad++; $display("FAIL line_video_on got %0d want 1280", vo_high); end
    n_cmp++; if (tick_cnt !== 799) begin n_bad++; $display("FAIL line_tick_cnt got %0d want 799", tick_cnt); end
    n_cmp++; if (tick_err !== 0) begin n_bad++; $display("FAIL line_tick_pattern got %0d bad want 0", tick_err); end
    n_cmp++; if (y_err !== 0) begin n_bad++; $display("FAIL line_pixel_y got %0d bad want 0", y_err); end
    n_cmp++; if (vs_low !== 0) begin n_bad++; $display("FAIL line_vsync got %0d low want 0", vs_low); end
    step(0, 1'b1);
    n_cmp++; if (pixel_y !== 10'd1) begin n_bad++; $display("FAIL wrap_pixel_y got %0d want 1", pixel_y); end
    n_cmp++; if (pixel_x !== 10'd0) begin n_bad++; $display("FAIL wrap_pixel_x got %0d want 0", pixel_x); end
  endtask

  task automatic test_vertical();
    for (int i = 0; i < 479; i++) step(0, 1'b1);
    n_cmp++; if (pixel_y !== 10'd480) begin n_bad++; $display("FAIL v480_pixel_y got %0d want 480", pixel_y); end
    clr_counts();
    drive_line(1'b0, 480);
    n_cmp++; if (vo_high !== 0) begin n_bad++; $display("FAIL v480_video_on got %0d high want 0", vo_high); end
    n_cmp++; if (y_err !== 0) begin n_bad++; $display("FAIL v480_pixel_y_hold got %0d bad want 0", y_err); end
    for (int i = 0; i < 9; i++) step(0, 1'b1);
    n_cmp++; if (pixel_y !== 10'd489) begin n_bad++; $display("FAIL v489_pixel_y got %0d want 489", pixel_y); end
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL v489_vsync got %b want 1", vsync); end
    clr_counts();
    drive_line(1'b1, 490);
    drive_line(1'b1, 491);
    n_cmp++; if (vs_low !== 3200) begin n_bad++; $display("FAIL vsync_len got %0d want 3200", vs_low); end
    n_cmp++; if (pvs_high !== 3200) begin n_bad++; $display("FAIL pol_vsync_len got %0d want 3200", pvs_high); end
    n_cmp++; if (y_err !== 0) begin n_bad++; $display("FAIL v490_pixel_y got %0d bad want 0", y_err); end
    step(0, 1'b1);
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL v492_vsync got %b want 1", vsync); end
    n_cmp++; if (pixel_y !== 10'd492) begin n_bad++; $display("FAIL v492_pixel_y got %0d want 492", pixel_y); end
  endtask

  task automatic test_frame();
    for (int i = 0; i < 32; i++) step(0, 1'b1);
    n_cmp++; if (pixel_y !== 10'd524) begin n_bad++; $display("FAIL v524_pixel_y got %0d want 524", pixel_y); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL v524_ftick got %b want 0", frame_tick); end
    step(0, 1'b1);
    n_cmp++; if (pixel_y !== 10'd0) begin n_bad++; $display("FAIL frame_pixel_y got %0d want 0", pixel_y); end
    n_cmp++; if (pixel_x !== 10'd0) begin n_bad++; $display("FAIL frame_pixel_x got %0d want 0", pixel_x); end
    n_cmp++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL frame_tick got %b want 1", frame_tick); end
    n_cmp++; if (frame_count !== 8'd1) begin n_bad++; $display("FAIL frame_count got %0d want 1", frame_count); end
    n_cmp++; if (video_on !== 1'b1) begin n_bad++; $display("FAIL frame_video_on got %b want 1", video_on); end
    step(0, 1'b0);
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL frame_tick_len got %b want 0", frame_tick); end
    n_cmp++; if (frame_count !== 8'd1) begin n_bad++; $display("FAIL frame_count_hold got %0d want 1", frame_count); end
  endtask

  task automatic test_frame_wrap();
    int ticks = 0;
    for (int f = 0; f < 256; f++) begin
      for (int l = 0; l < 7; l++) begin
        vflag_s = 1'b1;
        step(0, 1'b0);
        if (s_frame_tick === 1'b1) ticks++;
      end
      if (f == 254) begin
        n_cmp++;
        if (s_frame_count !== 8'd255) begin
          n_bad++; $display("FAIL fc_255 got %0d want 255", s_frame_count);
        end
      end
    end
    vflag_s = 1'b0;
    n_cmp++; if (s_frame_count !== 8'd0) begin n_bad++; $display("FAIL fc_wrap got %0d want 0", s_frame_count); end
    n_cmp++; if (ticks !== 256) begin n_bad++; $display("FAIL fc_ticks got %0d want 256", ticks); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 299; i++) step(0, 1'b1);
    n_cmp++; if (pixel_y !== 10'd299) begin n_bad++; $display("FAIL v299_pixel_y got %0d want 299", pixel_y); end
    Reset = 1'b1;
    step(0, 1'b1);
    Reset = 1'b0;
    n_cmp++; if (pixel_y !== 10'd0) begin n_bad++; $display("FAIL mid_rst_pixel_y got %0d want 0", pixel_y); end
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL mid_rst_vsync got %b want 1", vsync); end
    n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL mid_rst_hsync got %b want 1", hsync); end
    n_cmp++; if (frame_count !== 8'd0) begin n_bad++; $display("FAIL mid_rst_fc got %0d want 0", frame_count); end
    step(0, 1'b1);
    n_cmp++; if (pixel_y !== 10'd1) begin n_bad++; $display("FAIL post_rst_pixel_y got %0d want 1", pixel_y); end
    n_cmp++; if (frame_count !== 8'd0) begin n_bad++; $display("FAIL post_rst_fc got %0d want 0", frame_count); end
  endtask

  task automatic test_overrange();
    step(700, 1'b0);
    n_cmp++; if (hsync !== 1'b0) begin n_bad++; $display("FAIL h700_hsync got %b want 0", hsync); end
    n_cmp++; if (p_hsync !== 1'b1) begin n_bad++; $display("FAIL h700_pol_hsync got %b want 1", p_hsync); end
    step(900, 1'b0);
    n_cmp++; if (video_on !== 1'b0) begin n_bad++; $display("FAIL h900_video_on got %b want 0", video_on); end
    n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL h900_hsync got %b want 1", hsync); end
    n_cmp++; if (p_hsync !== 1'b0) begin n_bad++; $display("FAIL h900_pol_hsync got %b want 0", p_hsync); end
    n_cmp++; if (pixel_y !== 10'd1) begin n_bad++; $display("FAIL h900_pixel_y got %0d want 1", pixel_y); end
    n_cmp++; if (pixel_x !== 10'd900) begin n_bad++; $display("FAIL h900_pixel_x got %0d want 900", pixel_x); end
  endtask

  initial begin
    cnt_h = '0;
    vflag = 1'b0;
    vflag_s = 1'b0;
    Reset = 1'b1;
    test_reset();
    test_line();
    test_vertical();
    test_frame();
    test_frame_wrap();
    test_reset_mid();
    test_overrange();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
